// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per clock, with signs restored in a final step.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic               div_op;
    logic               neg_a;
    logic               neg_b;
    logic [WIDTH-1:0]   operand;
    logic [2*WIDTH-1:0] acc;

    logic               a_neg_in;
    logic               b_neg_in;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    // op[0]=0 selects the signed variants; unsigned operands never count as negative
    assign a_neg_in = ~op[0] & a[WIDTH-1];
    assign b_neg_in = ~op[0] & b[WIDTH-1];
    assign a_mag    = a_neg_in ? -a : a;
    assign b_mag    = b_neg_in ? -b : b;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        div_trial = acc[2*WIDTH-1:WIDTH-1];
        div_diff  = div_trial - {1'b0, operand};
        if (div_diff[WIDTH])
            div_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        else
            div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        prod_fix = (neg_a ^ neg_b) ? -acc : acc;
        quot_fix = (neg_a ^ neg_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            div_op   <= 1'b0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            operand  <= '0;
            acc      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        div_op   <= op[1];
                        neg_a    <= a_neg_in;
                        neg_b    <= b_neg_in;
                        operand  <= op[1] ? b_mag : a_mag;
                        acc      <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
                        div_zero <= 1'b0;
                        count    <= CW'(WIDTH);
                        busy     <= 1'b1;
                        state    <= (op[1] && b == '0) ? FIX : RUN;
                    end
                end
                RUN: begin
                    acc   <= div_op ? div_next : mul_next;
                    count <= count - CW'(1);
                    if (count == CW'(1))
                        state <= FIX;
                end
                FIX: begin
                    // a zero divisor leaves hi/lo untouched and only raises the flag
                    if (div_op && operand == '0) begin
                        div_zero <= 1'b1;
                    end else if (div_op) begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: a 32-bit instance for directed cases and
// an 8-bit instance for randomized traffic, both checked against integer arithmetic.
module tb_mult_div_unit;
    localparam int W_BIG   = 32;
    localparam int W_SMALL = 8;

    typedef struct {
        logic [63:0] hi;
        logic [63:0] lo;
        logic        dz;
        int          lat;
        longint      e0;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset32, start32, busy32, done32, dz32;
    logic [1:0]  op32;
    logic [31:0] a32, b32, hi32, lo32;
    logic        reset8, start8, busy8, done8, dz8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8, hi8, lo8;

    longint      cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        q32[$];
    exp_t        q8[$];
    logic [63:0] model_hi [2] = '{64'd0, 64'd0};
    logic [63:0] model_lo [2] = '{64'd0, 64'd0};

    mult_div_unit #(.WIDTH(W_BIG)) dut32 (
        .clock(clock), .reset(reset32), .start(start32), .op(op32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .div_zero(dz32), .hi(hi32), .lo(lo32)
    );

    mult_div_unit #(.WIDTH(W_SMALL)) dut8 (
        .clock(clock), .reset(reset8), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic longint sext(input logic [63:0] x, input int w);
        longint v;
        v = x << (64 - w);
        return v >>> (64 - w);
    endfunction

    // Expected result from plain integer arithmetic on the operands
    function automatic exp_t ref_model(input logic [1:0] op, input logic [63:0] a_in,
                                       input logic [63:0] b_in, input int w,
                                       input logic [63:0] prev_hi, input logic [63:0] prev_lo);
        exp_t        e;
        logic [63:0] mask, ua, ub, p;
        longint      sa, sb;
        mask = (64'd1 << w) - 64'd1;
        ua   = a_in & mask;
        ub   = b_in & mask;
        sa   = sext(ua, w);
        sb   = sext(ub, w);
        e.dz  = 1'b0;
        e.lat = w + 1;
        e.e0  = 0;
        e.hi  = prev_hi;
        e.lo  = prev_lo;
        case (op)
            2'b00: begin p = sa * sb; e.hi = (p >> w) & mask; e.lo = p & mask; end
            2'b01: begin p = ua * ub; e.hi = (p >> w) & mask; e.lo = p & mask; end
            2'b10: begin
                if (ub == 64'd0) begin
                    e.dz = 1'b1; e.lat = 1;
                end else begin
                    e.lo = 64'(sa / sb) & mask;
                    e.hi = 64'(sa % sb) & mask;
                end
            end
            default: begin
                if (ub == 64'd0) begin
                    e.dz = 1'b1; e.lat = 1;
                end else begin
                    e.lo = ua / ub;
                    e.hi = ua % ub;
                end
            end
        endcase
        return e;
    endfunction

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
        end
    endtask

    task automatic drive(input int inst, input logic s, input logic [1:0] o,
                         input logic [63:0] x, input logic [63:0] y);
        if (inst == 0) begin
            start32 = s; op32 = o; a32 = x[31:0]; b32 = y[31:0];
        end else begin
            start8 = s; op8 = o; a8 = x[7:0]; b8 = y[7:0];
        end
    endtask

    task automatic monitor_result(input int inst, input logic [63:0] hi, input logic [63:0] lo,
                                  input logic dz, input logic bsy);
        exp_t  e;
        string tag;
        bit    empty;
        tag = (inst == 0) ? "w32" : "w8";
        check_output({tag, "_busy_with_done"}, 64'(bsy), 64'd0);
        empty = (inst == 0) ? (q32.size() == 0) : (q8.size() == 0);
        if (empty) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_unexpected_done actual=done required=no_done", tag);
        end else begin
            if (inst == 0) e = q32.pop_front();
            else           e = q8.pop_front();
            check_output({tag, "_hi"}, hi, e.hi);
            check_output({tag, "_lo"}, lo, e.lo);
            check_output({tag, "_div_zero"}, 64'(dz), 64'(e.dz));
            check_output({tag, "_latency"}, 64'(cyc - e.e0), 64'(e.lat));
        end
    endtask

    always @(negedge clock) begin
        if (done32) monitor_result(0, {32'd0, hi32}, {32'd0, lo32}, dz32, busy32);
        if (done8)  monitor_result(1, {56'd0, hi8}, {56'd0, lo8}, dz8, busy8);
    end

    // Issue one operation, then scramble inputs and start while busy until done
    task automatic apply_stimulus(input int inst, input logic [1:0] op,
                                  input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        int   w, busy_cnt;
        bit   finished;
        w = (inst == 0) ? W_BIG : W_SMALL;
        e = ref_model(op, a, b, w, model_hi[inst], model_lo[inst]);
        model_hi[inst] = e.hi;
        model_lo[inst] = e.lo;
        drive(inst, 1'b1, op, a, b);
        @(posedge clock);
        @(negedge clock);
        e.e0 = cyc;
        if (inst == 0) q32.push_back(e);
        else           q8.push_back(e);
        busy_cnt = 0;
        finished = 1'b0;
        for (int i = 0; i < 200 && !finished; i++) begin
            if ((inst == 0) ? busy32 : busy8) begin
                busy_cnt++;
                drive(inst, 1'($urandom_range(0, 1)), 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
                @(negedge clock);
            end else begin
                finished = 1'b1;
            end
        end
        drive(inst, 1'b0, op, a, b);
        if (!finished) begin
            checks++;
            errors++;
            $display("[TB] FAIL busy_timeout actual=busy required=idle");
        end
        check_output("busy_cycles", 64'(busy_cnt), 64'(e.lat));
    endtask

    task automatic check_reset_state(input int inst);
        if (inst == 0) begin
            check_output("rst32_busy", 64'(busy32), 64'd0);
            check_output("rst32_done", 64'(done32), 64'd0);
            check_output("rst32_dz",   64'(dz32),   64'd0);
            check_output("rst32_hi",   64'(hi32),   64'd0);
            check_output("rst32_lo",   64'(lo32),   64'd0);
        end else begin
            check_output("rst8_busy", 64'(busy8), 64'd0);
            check_output("rst8_done", 64'(done8), 64'd0);
            check_output("rst8_dz",   64'(dz8),   64'd0);
            check_output("rst8_hi",   64'(hi8),   64'd0);
            check_output("rst8_lo",   64'(lo8),   64'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset32 = 1'b0;
        reset8  = 1'b0;
        drive(0, 1'b0, 2'b00, 64'd0, 64'd0);
        drive(1, 1'b0, 2'b00, 64'd0, 64'd0);
        repeat (3) @(negedge clock);
        check_reset_state(0);
        check_reset_state(1);
        reset32 = 1'b1;
        reset8  = 1'b1;
        @(negedge clock);

        apply_stimulus(0, 2'b01, 64'hFFFFFFFF, 64'hFFFFFFFF);
        check_output("multu_max_hi", {32'd0, hi32}, 64'hFFFFFFFE);
        check_output("multu_max_lo", {32'd0, lo32}, 64'h00000001);
        apply_stimulus(0, 2'b00, 64'hFFFFFFFD, 64'd7);
        check_output("mult_neg_hi", {32'd0, hi32}, 64'hFFFFFFFF);
        check_output("mult_neg_lo", {32'd0, lo32}, 64'hFFFFFFEB);
        apply_stimulus(0, 2'b10, 64'hFFFFFFF9, 64'd2);
        check_output("div_neg_lo", {32'd0, lo32}, 64'hFFFFFFFD);
        check_output("div_neg_hi", {32'd0, hi32}, 64'hFFFFFFFF);
        apply_stimulus(0, 2'b10, 64'h80000000, 64'hFFFFFFFF);
        check_output("div_wrap_lo", {32'd0, lo32}, 64'h80000000);
        check_output("div_wrap_hi", {32'd0, hi32}, 64'd0);
        check_output("div_wrap_dz", 64'(dz32), 64'd0);
        apply_stimulus(0, 2'b11, 64'd100, 64'd7);
        check_output("divu_lo", {32'd0, lo32}, 64'd14);
        check_output("divu_hi", {32'd0, hi32}, 64'd2);
        apply_stimulus(0, 2'b11, 64'd100, 64'd0);
        repeat (3) @(negedge clock);
        check_output("dz_held", 64'(dz32), 64'd1);
        check_output("dz_hi_kept", {32'd0, hi32}, 64'd2);
        check_output("dz_lo_kept", {32'd0, lo32}, 64'd14);
        apply_stimulus(0, 2'b01, 64'd2, 64'd3);
        check_output("after_dz_flag", 64'(dz32), 64'd0);
        check_output("after_dz_lo", {32'd0, lo32}, 64'd6);
        check_output("after_dz_hi", {32'd0, hi32}, 64'd0);

        // Abandon an operation with an asynchronous reset partway through
        drive(0, 1'b1, 2'b01, 64'h1234, 64'h5678);
        @(posedge clock);
        @(negedge clock);
        drive(0, 1'b0, 2'b01, 64'h1234, 64'h5678);
        repeat (4) @(negedge clock);
        drive(0, 1'b1, 2'b01, 64'd9, 64'd9);
        @(negedge clock);
        drive(0, 1'b0, 2'b01, 64'd9, 64'd9);
        repeat (4) @(negedge clock);
        check_output("mid_op_busy", 64'(busy32), 64'd1);
        #2 reset32 = 1'b0;
        #1 check_reset_state(0);
        model_hi[0] = 64'd0;
        model_lo[0] = 64'd0;
        repeat (2) @(negedge clock);
        reset32 = 1'b1;
        repeat (3) @(negedge clock);
        apply_stimulus(0, 2'b01, 64'd5, 64'd5);
        check_output("post_reset_lo", {32'd0, lo32}, 64'd25);

        apply_stimulus(1, 2'b10, 64'h80, 64'hFF);
        check_output("w8_wrap_lo", {56'd0, lo8}, 64'h80);
        check_output("w8_wrap_hi", {56'd0, hi8}, 64'd0);
        for (int opc = 0; opc < 4; opc++) begin
            for (int n = 0; n < 1000; n++) begin
                logic [63:0] ra, rb;
                ra = 64'($urandom);
                rb = 64'($urandom);
                if ($urandom_range(0, 9) == 0) rb = 64'd0;
                apply_stimulus(1, 2'(opc), ra, rb);
            end
        end

        repeat (5) @(negedge clock);
        check_output("w32_queue_drained", 64'(q32.size()), 64'd0);
        check_output("w8_queue_drained",  64'(q8.size()),  64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving operand width; legal values are even integers 4..64.
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset).
REQ-004 The block SHALL have port start, input, 1, a request to begin an operation, sampled only in IDLE.
REQ-005 The block SHALL have port op, input, 2, the operation: 00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU.
REQ-006 The block SHALL have port a, input, WIDTH, the multiplicand or dividend.
REQ-007 The block SHALL have port b, input, WIDTH, the multiplier or divisor.
REQ-008 The block SHALL have port busy, output, 1, high while an accepted operation is in progress.
REQ-009 The block SHALL have port done, output, 1, a one-cycle pulse when the result is written.
REQ-010 The block SHALL have port div_zero, output, 1, set when a DIV/DIVU has divisor 0.
REQ-011 The block SHALL have port hi, output, WIDTH, holding the upper product half or the remainder.
REQ-012 The block SHALL have port lo, output, WIDTH, holding the lower product half or the quotient.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and FIX, and SHALL hold a step counter of ceil(log2(WIDTH+1)) bits.
REQ-014 In IDLE with start=1, edge E0 SHALL latch a, b and op, clear div_zero, load counter=WIDTH and go to RUN; later changes to a, b or op SHALL have no effect.
REQ-015 In RUN, each edge SHALL perform one iteration on operand magnitudes (shift-add multiply, or restoring divide); the counter SHALL decrement, and counter reaching 0 SHALL move the FSM to FIX.
REQ-016 In FIX, the edge SHALL apply sign correction, write hi and lo, pulse done=1 for one cycle and return to IDLE.
REQ-017 done SHALL rise WIDTH+1 edges after E0 (33 for WIDTH=32); busy SHALL be 1 from E0 until the edge that raises done, and busy and done SHALL never both be 1.
REQ-018 MULT/MULTU SHALL produce {hi,lo} equal to the exact 2*WIDTH-bit signed or unsigned product.
REQ-019 DIV/DIVU SHALL set lo to the quotient truncated toward zero and hi to the remainder, with the remainder taking the sign of the dividend for DIV.
REQ-020 DIV of the most negative value by -1 SHALL give lo = most negative value (wrap) and hi = 0, with no flag.
REQ-021 DIV/DIVU with b=0 at E0 SHALL go directly to FIX (skipping RUN); at E1 done=1 and div_zero=1, and hi and lo SHALL be left unchanged.
REQ-022 div_zero SHALL hold until the next accepted start.
REQ-023 start while busy SHALL be ignored; start in the cycle done=1 SHALL be accepted, since the FSM is then in IDLE.
REQ-024 hi and lo SHALL change only at a FIX edge or on reset, and SHALL otherwise retain their value indefinitely.

Reset
REQ-025 reset=0 SHALL immediately, without waiting for clock, force state=IDLE, counter=0, busy=0, done=0, div_zero=0, hi=0 and lo=0.
REQ-026 Reset asserted mid-operation SHALL abandon the operation without writing a partial result, and the first start after reset release SHALL be accepted normally.

Verification
REQ-027 WIDTH=32, MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done exactly 33 edges after E0, busy high for 33 cycles.
REQ-028 MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; then DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-029 DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0; DIVU a=100 b=7 -> lo=14, hi=2.
REQ-030 DIVU a=100 b=0 with hi/lo holding prior values -> done and div_zero=1 one edge after E0, hi/lo unchanged; next MULTU 2*3 clears div_zero and gives lo=6, hi=0.
REQ-031 Start MULTU, pulse start again at cycle 5 (ignored), assert reset=0 asynchronously at cycle 10 -> busy=0, hi=lo=0 before next edge, no done pulse; after release MULTU 5*5 -> lo=25.
REQ-032 WIDTH=8: random 1000 ops per op code vs reference model -> all hi/lo match; done 9 edges after E0 (1 edge for divide by zero).
